// File: rtl/minirv_multicycle.sv
// Multi-cycle RV32 subset core: FETCH -> EXEC -> (MEM) -> WB, one memory port.
// Implements add/addi/lui/lw/lbu/sw/sb/jalr and halts on any fault until reset.
module minirv_multicycle #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        halted,
  output logic [31:0] instret,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  // Memory handshake: an access completes on a rising edge where mem_req and mem_ready are both 1.
  typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;

  localparam logic [31:0] NREGS = 32'(NUM_REGS);

  function automatic logic idx_ok(input logic [4:0] idx);
    return {27'b0, idx} < NREGS;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, alu_q, alu_d, rs2v_q, rs2v_d;
  logic [31:0] load_q, load_d, instret_q, instret_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        is_add, is_addi, is_lui, is_lw, is_lbu, is_sw, is_sb, is_jalr;
  logic        is_load, is_store, uses_rd, uses_rs1, uses_rs2, legal, bad_idx, misaligned;
  logic [31:0] imm_i, imm_s, rs1_val, rs2_val, op_b, alu, pc_plus4, wb_val;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  assign is_add  = (opcode == 7'h33) && (funct3 == 3'd0) && (funct7 == 7'd0);
  assign is_addi = (opcode == 7'h13) && (funct3 == 3'd0);
  assign is_lui  = (opcode == 7'h37);
  assign is_lw   = (opcode == 7'h03) && (funct3 == 3'd2);
  assign is_lbu  = (opcode == 7'h03) && (funct3 == 3'd4);
  assign is_sw   = (opcode == 7'h23) && (funct3 == 3'd2);
  assign is_sb   = (opcode == 7'h23) && (funct3 == 3'd0);
  assign is_jalr = (opcode == 7'h67) && (funct3 == 3'd0);

  assign is_load  = is_lw | is_lbu;
  assign is_store = is_sw | is_sb;
  assign uses_rd  = is_add | is_addi | is_lui | is_load | is_jalr;
  assign uses_rs1 = is_add | is_addi | is_load | is_store | is_jalr;
  assign uses_rs2 = is_add | is_store;
  assign legal    = uses_rd | is_store;
  assign bad_idx  = (uses_rd && !idx_ok(rd)) || (uses_rs1 && !idx_ok(rs1)) ||
                    (uses_rs2 && !idx_ok(rs2));

  // Entries at or above NUM_REGS are never written and never read, so they trim away.
  assign rs1_val = idx_ok(rs1) ? regs_q[rs1] : 32'h0;
  assign rs2_val = idx_ok(rs2) ? regs_q[rs2] : 32'h0;
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign op_b    = is_add ? rs2_val : (is_store ? imm_s : imm_i);
  assign alu     = rs1_val + op_b;
  assign misaligned = ((is_lw || is_sw) && (alu[1:0] != 2'b00)) || (is_jalr && alu[1]);

  assign pc_plus4 = pc_q + 32'd4;
  assign wb_val   = is_lui  ? {ir_q[31:12], 12'h000} :
                    is_load ? load_q :
                    is_jalr ? pc_plus4 : alu_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_d     = alu_q;
    rs2v_d    = rs2v_q;
    load_d    = load_q;
    instret_d = instret_q;
    regs_d    = regs_q;
    case (state_q)
      FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        alu_d  = alu;
        rs2v_d = rs2_val;
        if (!legal || bad_idx || misaligned) state_d = HALT;
        else if (is_load || is_store)        state_d = MEM;
        else                                 state_d = WB;
      end
      MEM: if (mem_ready) begin
        if (is_load) begin
          load_d  = is_lw ? mem_rdata : {24'h0, mem_rdata[{alu_q[1:0], 3'b000} +: 8]};
          state_d = WB;
        end else begin
          pc_d      = pc_plus4;
          instret_d = instret_q + 32'd1;
          state_d   = FETCH;
        end
      end
      WB: begin
        if (rd != 5'd0) regs_d[rd] = wb_val;
        // The jalr target was latched in EXEC, so rd == rs1 cannot disturb it.
        pc_d      = is_jalr ? {alu_q[31:1], 1'b0} : pc_plus4;
        instret_d = instret_q + 32'd1;
        state_d   = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      alu_q     <= '0;
      rs2v_q    <= '0;
      load_q    <= '0;
      instret_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_q     <= alu_d;
      rs2v_q    <= rs2v_d;
      load_q    <= load_d;
      instret_q <= instret_d;
      regs_q    <= regs_d;
    end
  end

  // rst gates mem_req directly so an abandoned access drops without a clock edge.
  assign mem_req   = !rst && ((state_q == FETCH) || (state_q == MEM));
  assign mem_we    = (state_q == MEM) && is_store;
  assign mem_addr  = (state_q == MEM) ? alu_q : pc_q;
  assign mem_wdata = !mem_we ? 32'h0 : (is_sw ? rs2v_q : {4{rs2v_q[7:0]}});
  assign mem_wstrb = !mem_we ? 4'b0000 : (is_sw ? 4'b1111 : (4'b0001 << alu_q[1:0]));

  assign pc_out      = pc_q;
  assign instruction = ir_q;
  assign halted      = (state_q == HALT);
  assign instret     = instret_q;
  assign dbg_data    = ((dbg_addr != 5'd0) && idx_ok(dbg_addr)) ? regs_q[dbg_addr] : 32'h0;
endmodule
